// File: rtl/memory_bus_master.sv
// Single-beat memory bus master: latches a CPU request, runs a four-phase
// RD/WR handshake with timeout, and reports completion with DONE/ERROR.
//
// Ports:
//   MEMORY_BUS_MASTER_CLOCK_50           clock, rising edge
//   MEMORY_BUS_MASTER_RESET_InLow        async active-low reset
//   MEMORY_BUS_MASTER_REQ_In/_WE_In      CPU request, 1 = write
//   MEMORY_BUS_MASTER_ADDRESS_InBUS      CPU byte address
//   MEMORY_BUS_MASTER_WDATA_InBUS        CPU write data
//   MEMORY_BUS_MASTER_BUSY_Out           high outside IDLE
//   MEMORY_BUS_MASTER_DONE_Out           one-cycle completion pulse
//   MEMORY_BUS_MASTER_ERROR_Out          status, valid with DONE
//   MEMORY_BUS_MASTER_RDATA_OutBUS       last read data
//   MEMORY_BUS_MASTER_MEM_*              memory-side address/data/strobes/ack
module memory_bus_master #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     MEMORY_BUS_MASTER_CLOCK_50,
  input  logic                     MEMORY_BUS_MASTER_RESET_InLow,
  input  logic                     MEMORY_BUS_MASTER_REQ_In,
  input  logic                     MEMORY_BUS_MASTER_WE_In,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_ADDRESS_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_WDATA_InBUS,
  output logic                     MEMORY_BUS_MASTER_BUSY_Out,
  output logic                     MEMORY_BUS_MASTER_DONE_Out,
  output logic                     MEMORY_BUS_MASTER_ERROR_Out,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_RDATA_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_MEM_ADDRESS_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_MEM_data_OutBUS,
  output logic                     MEMORY_BUS_MASTER_MEM_RD_Out,
  output logic                     MEMORY_BUS_MASTER_MEM_WR_Out,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_BUS_MASTER_MEM_data_InBUS,
  input  logic                     MEMORY_BUS_MASTER_MEM_ACK_In
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE,
    DONE
  } state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       we_q;

  logic clk;
  logic rst_n;
  logic req;
  logic ack;

  assign clk   = MEMORY_BUS_MASTER_CLOCK_50;
  assign rst_n = MEMORY_BUS_MASTER_RESET_InLow;
  assign req   = MEMORY_BUS_MASTER_REQ_In;
  assign ack   = MEMORY_BUS_MASTER_MEM_ACK_In;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                                <= IDLE;
      cnt                                  <= '0;
      we_q                                 <= 1'b0;
      MEMORY_BUS_MASTER_BUSY_Out           <= 1'b0;
      MEMORY_BUS_MASTER_DONE_Out           <= 1'b0;
      MEMORY_BUS_MASTER_ERROR_Out          <= 1'b0;
      MEMORY_BUS_MASTER_RDATA_OutBUS       <= '0;
      MEMORY_BUS_MASTER_MEM_ADDRESS_OutBUS <= '0;
      MEMORY_BUS_MASTER_MEM_data_OutBUS    <= '0;
      MEMORY_BUS_MASTER_MEM_RD_Out         <= 1'b0;
      MEMORY_BUS_MASTER_MEM_WR_Out         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            we_q                                 <= MEMORY_BUS_MASTER_WE_In;
            MEMORY_BUS_MASTER_MEM_ADDRESS_OutBUS <= MEMORY_BUS_MASTER_ADDRESS_InBUS;
            MEMORY_BUS_MASTER_MEM_data_OutBUS    <= MEMORY_BUS_MASTER_WDATA_InBUS;
            MEMORY_BUS_MASTER_BUSY_Out           <= 1'b1;
            if (MEMORY_BUS_MASTER_ADDRESS_InBUS[1:0] == 2'b00) begin
              state                        <= ACCESS;
              cnt                          <= '0;
              MEMORY_BUS_MASTER_MEM_RD_Out <= ~MEMORY_BUS_MASTER_WE_In;
              MEMORY_BUS_MASTER_MEM_WR_Out <= MEMORY_BUS_MASTER_WE_In;
            end else begin
              // misaligned: report straight away, never touch the bus
              state                       <= DONE;
              MEMORY_BUS_MASTER_ERROR_Out <= 1'b1;
              MEMORY_BUS_MASTER_DONE_Out  <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (!ack) begin
            cnt <= cnt + 8'd1;
          end
          // ack is tested first so it wins over a coincident timeout
          if (ack) begin
            state                        <= RELEASE;
            MEMORY_BUS_MASTER_MEM_RD_Out <= 1'b0;
            MEMORY_BUS_MASTER_MEM_WR_Out <= 1'b0;
            MEMORY_BUS_MASTER_ERROR_Out  <= 1'b0;
            if (!we_q) begin
              MEMORY_BUS_MASTER_RDATA_OutBUS <= MEMORY_BUS_MASTER_MEM_data_InBUS;
            end
          end else if (cnt == LAST) begin
            state                        <= RELEASE;
            MEMORY_BUS_MASTER_MEM_RD_Out <= 1'b0;
            MEMORY_BUS_MASTER_MEM_WR_Out <= 1'b0;
            MEMORY_BUS_MASTER_ERROR_Out  <= 1'b1;
            if (!we_q) begin
              MEMORY_BUS_MASTER_RDATA_OutBUS <= '0;
            end
          end
        end
        RELEASE: begin
          // wait for the slave to drop ack before finishing
          if (!ack) begin
            state                      <= DONE;
            MEMORY_BUS_MASTER_DONE_Out <= 1'b1;
          end
        end
        DONE: begin
          state                      <= IDLE;
          MEMORY_BUS_MASTER_DONE_Out <= 1'b0;
          MEMORY_BUS_MASTER_BUSY_Out <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus_master.sv
// Randomized self-checking bench for memory_bus_master against a
// transaction-level reference model of the bus handshake.
module tb_memory_bus_master;

  localparam int W = 32;
  localparam int T = 16;

  logic         clk;
  logic         rst_n;
  logic         req;
  logic         we;
  logic [W-1:0] addr;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] rdata;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_dout;
  logic         rd;
  logic         wr;
  logic [W-1:0] mem_din;
  logic         ack;

  int n_vec;
  int n_err;

  logic [W-1:0] model_rdata;
  logic [W-1:0] mem [logic [W-1:0]];

  memory_bus_master #(
    .DATAWIDTH_BUS (W),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .MEMORY_BUS_MASTER_CLOCK_50          (clk),
    .MEMORY_BUS_MASTER_RESET_InLow       (rst_n),
    .MEMORY_BUS_MASTER_REQ_In            (req),
    .MEMORY_BUS_MASTER_WE_In             (we),
    .MEMORY_BUS_MASTER_ADDRESS_InBUS     (addr),
    .MEMORY_BUS_MASTER_WDATA_InBUS       (wdata),
    .MEMORY_BUS_MASTER_BUSY_Out          (busy),
    .MEMORY_BUS_MASTER_DONE_Out          (done),
    .MEMORY_BUS_MASTER_ERROR_Out         (err),
    .MEMORY_BUS_MASTER_RDATA_OutBUS      (rdata),
    .MEMORY_BUS_MASTER_MEM_ADDRESS_OutBUS(mem_addr),
    .MEMORY_BUS_MASTER_MEM_data_OutBUS   (mem_dout),
    .MEMORY_BUS_MASTER_MEM_RD_Out        (rd),
    .MEMORY_BUS_MASTER_MEM_WR_Out        (wr),
    .MEMORY_BUS_MASTER_MEM_data_InBUS    (mem_din),
    .MEMORY_BUS_MASTER_MEM_ACK_In        (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mem_rd(input logic [W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Called at a negedge with the DUT idle. lat = strobe cycle in which
  // the slave acks (beyond T means never); hold = release cycles with
  // ack still high; keep = leave req asserted throughout.
  task automatic run_txn(input logic t_we, input logic [W-1:0] t_addr,
                         input logic [W-1:0] t_wdata, input int lat,
                         input int hold, input bit keep);
    bit           mis;
    bit           to;
    int           e_s;
    int           e_r;
    int           e_done;
    logic         e_err;
    logic [W-1:0] e_rdata;
    logic [W-1:0] rv;
    int           scnt;
    int           rcnt;
    int           bad;
    int           done_at;
    logic         err_at;
    bit           acked;
    bit           seen;
    bit           fin;

    mis     = (t_addr[1:0] != 2'b00);
    to      = (lat > T);
    rv      = mem_rd(t_addr);
    e_s     = mis ? 0 : (to ? T : lat);
    e_r     = mis ? 0 : (to ? 1 : hold + 1);
    e_done  = e_s + e_r + 1;
    e_err   = mis || to;
    e_rdata = model_rdata;
    if (!mis && !t_we) e_rdata = to ? '0 : rv;

    scnt = 0; rcnt = 0; bad = 0; done_at = 0; err_at = 1'b0;
    acked = 0; seen = 0; fin = 0;
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; ack = 1'b0;

    for (int k = 1; k <= 200 && !fin; k++) begin
      @(negedge clk);
      if (!keep) req = 1'b0;
      if (seen) begin
        chk("busy_after_done", busy, 1'b0);
        chk("done_width", done, 1'b0);
        if (!mis) chk("addr_hold", mem_addr, t_addr);
        fin = 1;
        ack = 1'b0;
      end else begin
        if (rd || wr) begin
          scnt++;
          if (rd == t_we || wr != t_we) bad++;
          if (mem_addr != t_addr) bad++;
          if (t_we && mem_dout != t_wdata) bad++;
        end else if (done) begin
          seen = 1; done_at = k; err_at = err;
        end else if (busy) begin
          rcnt++;
        end
        ack = 1'b0;
        if (rd || wr) ack = (scnt == lat);
        else if (busy && !done) ack = acked && (rcnt <= hold);
        if ((rd || wr) && ack) begin
          acked = 1;
          if (t_we) mem[t_addr] = t_wdata;
        end
        mem_din = (ack && !t_we) ? rv : W'($urandom);
      end
    end
    if (!fin) chk("no_done_in_budget", 0, 1);
    chk("strobe_cycles", scnt, e_s);
    chk("release_cycles", rcnt, e_r);
    chk("done_latency", done_at, e_done);
    chk("error", err_at, e_err);
    chk("strobe_bus", bad, 0);
    chk("rdata", rdata, e_rdata);
    model_rdata = e_rdata;
    req = keep;
  endtask

  initial begin
    n_vec = 0; n_err = 0; model_rdata = '0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    ack = 1'b0; mem_din = '0;
    #3;
    chk("rst_flags", {27'd0, busy, done, err, rd, wr}, '0);
    chk("rst_rdata", rdata, '0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_data", mem_dout, '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_txn(1'b0, 32'h800, 32'h0, 3, 0, 0);
    run_txn(1'b1, 32'h804, 32'h1234_5678, 2, 0, 0);
    run_txn(1'b0, 32'h808, 32'h0, T + 1, 2, 0);
    run_txn(1'b0, 32'h802, 32'h0, 1, 0, 0);
    run_txn(1'b0, 32'h804, 32'h0, 2, 5, 0);
    run_txn(1'b0, 32'h800, 32'h0, T, 0, 0);
    run_txn(1'b1, 32'h80C, 32'hCAFE_F00D, 1, 0, 0);
    run_txn(1'b0, 32'h80C, 32'h0, 1, 1, 0);
    run_txn(1'b1, 32'h811, 32'hDEAD_BEEF, 1, 0, 0);
    run_txn(1'b0, 32'h100, 32'h0, 2, 0, 1);
    run_txn(1'b0, 32'h100, 32'h0, 3, 1, 0);

    // reset in the middle of a read
    req = 1'b1; we = 1'b0; addr = 32'h40; ack = 1'b0;
    @(negedge clk); req = 1'b0;
    chk("pre_rst_rd", rd, 1'b1);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rd_drop", rd, 1'b0);
    chk("async_busy_drop", busy, 1'b0);
    chk("async_rdata_clr", rdata, '0);
    model_rdata = '0;
    @(negedge clk); rst_n = 1'b1;
    begin
      int dn;
      dn = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        dn += int'(done) + int'(busy);
      end
      chk("no_done_after_rst", dn, 0);
    end
    run_txn(1'b0, 32'h800, 32'h0, 2, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      a = {24'h0, 6'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      run_txn(1'($urandom), a, W'($urandom), $urandom_range(1, T + 2),
              $urandom_range(0, 3), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
